// File: rtl/vrf_access_sequencer.sv
// rtl/vrf_access_sequencer.sv - burst load/store sequencer in front of the vector register file SRAM
// Optional statistics counters are enabled by defining VRF_SEQ_STATS_EN.
`timescale 1ns/1ps

module vrf_access_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_base,
  input  logic [ADDR_WIDTH-1:0] req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic                  sram_oe,
  inout  wire  [DATA_WIDTH-1:0] sram_data
`ifdef VRF_SEQ_STATS_EN
  ,
  output logic [15:0]           stat_wr_words,
  output logic [15:0]           stat_rd_words
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] remaining_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  done_wr_q;

  // Two-entry read return buffer: head pointer plus occupancy
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic                  buf_head;
  logic [1:0]            buf_count;

  logic                  wr_fire;
  logic                  rd_push;
  logic                  rd_pop;
  logic [1:0]            count_next;
  logic                  rd_issue;
  logic                  drain_done;
  logic                  wr_idx;

  // The bus is only driven while a write cycle is on the pins
  assign sram_data = (sram_we && !sram_oe) ? wdata_q : {DATA_WIDTH{1'bz}};

  // A read issued last cycle returns its word during the current cycle
  assign rd_push    = sram_cs && sram_oe;
  assign rd_valid   = (buf_count != 2'd0);
  assign rd_data    = buf_data[buf_head];
  assign rd_pop     = rd_valid && rd_ready;
  assign count_next = buf_count + {1'b0, rd_push} - {1'b0, rd_pop};
  assign wr_idx     = buf_head ^ buf_count[0];

  // A new read only goes out if its word is sure to find a free slot on return
  assign rd_issue   = (state_q == S_READ) && (count_next < 2'd2);
  assign wr_fire    = (state_q == S_WRITE) && wr_valid && wr_ready;

  // Read completion coincides with the handshake of the very last buffered word
  assign drain_done = (state_q == S_DRAIN) && !sram_oe && (buf_count == 2'd1) && rd_ready;
  assign done       = done_wr_q || drain_done;

  // Burst control FSM with registered SRAM pins and handshake readies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      wdata_q      <= '0;
      done_wr_q    <= 1'b0;
      req_ready    <= 1'b1;
      wr_ready     <= 1'b0;
      sram_address <= '0;
      sram_cs      <= 1'b0;
      sram_we      <= 1'b0;
      sram_oe      <= 1'b0;
    end else begin
      sram_cs   <= 1'b0;
      sram_we   <= 1'b0;
      sram_oe   <= 1'b0;
      done_wr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            addr_q      <= req_base;
            remaining_q <= req_len;
            req_ready   <= 1'b0;
            wr_ready    <= req_write;
            state_q     <= req_write ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (wr_fire) begin
            wdata_q      <= wr_data;
            sram_cs      <= 1'b1;
            sram_we      <= 1'b1;
            sram_address <= addr_q;
            addr_q       <= addr_q + ADDR_WIDTH'(1);
            remaining_q  <= remaining_q - ADDR_WIDTH'(1);
            if (remaining_q == '0) begin
              // Last word goes to the pins next cycle; done rides along with it
              done_wr_q <= 1'b1;
              wr_ready  <= 1'b0;
              req_ready <= 1'b1;
              state_q   <= S_IDLE;
            end
          end
        end
        S_READ: begin
          if (rd_issue) begin
            sram_cs      <= 1'b1;
            sram_oe      <= 1'b1;
            sram_address <= addr_q;
            addr_q       <= addr_q + ADDR_WIDTH'(1);
            remaining_q  <= remaining_q - ADDR_WIDTH'(1);
            if (remaining_q == '0) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_done || (count_next == 2'd0 && !sram_oe)) begin
            req_ready <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          wr_ready  <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  // Return buffer: push the sampled SRAM word, pop on consumer handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_head    <= 1'b0;
      buf_count   <= 2'd0;
    end else begin
      if (rd_push) begin
        buf_data[wr_idx] <= sram_data;
      end
      if (rd_pop) begin
        buf_head <= ~buf_head;
      end
      buf_count <= count_next;
    end
  end

`ifdef VRF_SEQ_STATS_EN
  // Saturating word counters for performed writes and delivered reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr_words <= 16'd0;
      stat_rd_words <= 16'd0;
    end else begin
      if (sram_cs && sram_we && stat_wr_words != 16'hFFFF) begin
        stat_wr_words <= stat_wr_words + 16'd1;
      end
      if (rd_pop && stat_rd_words != 16'hFFFF) begin
        stat_rd_words <= stat_rd_words + 16'd1;
      end
    end
  end
`endif

endmodule
